// File: rtl/bcd_multi_digit_timer_if.sv
// bcd_multi_digit_timer_if: control inputs and status/count outputs of the BCD timer
//  master: drives i_clear/i_start/i_stop/i_tick, observes o_count/o_running/o_held/o_overflow/o_ripplecarryout
//  slave : the timer itself
interface bcd_multi_digit_timer_if #(parameter int DIGITS = 4);
  logic i_clear;
  logic i_start;
  logic i_stop;
  logic i_tick;
  logic [4*DIGITS-1:0] o_count;
  logic o_running;
  logic o_held;
  logic o_overflow;
  logic o_ripplecarryout;
  modport master (output i_clear, i_start, i_stop, i_tick,
                  input o_count, o_running, o_held, o_overflow, o_ripplecarryout);
  modport slave (input i_clear, i_start, i_stop, i_tick,
                 output o_count, o_running, o_held, o_overflow, o_ripplecarryout);
endinterface

// File: rtl/bcd_multi_digit_timer.sv
// bcd_multi_digit_timer: cascaded-decade BCD tick counter with run/hold/overflow control
//  i_clk   : rising-edge clock
//  i_reset : asynchronous active-high reset to IDLE with all outputs 0
//  bus     : slave side of bcd_multi_digit_timer_if (clear/start/stop/tick in; count and status out)
module bcd_multi_digit_timer #(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 1
) (
  input logic i_clk,
  input logic i_reset,
  bcd_multi_digit_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, OVF} state_t;
  state_t r_state;
  logic [4*DIGITS-1:0] r_count, w_next;
  logic [DIGITS:0] w_carry;
  logic r_running, r_held, r_overflow, r_rco;
  // w_carry[d] means every lower digit is 9, so digit d advances on this tick;
  // w_carry[DIGITS] therefore flags an all-9s count about to roll over
  always_comb begin
    w_next = r_count;
    w_carry = '0;
    w_carry[0] = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      w_next[4*d+:4] = w_carry[d] ? (r_count[4*d+:4] == 4'd9 ? 4'd0 : r_count[4*d+:4] + 4'd1) : r_count[4*d+:4];
      w_carry[d+1] = w_carry[d] && r_count[4*d+:4] == 4'd9;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_running <= 1'b0;
      r_held <= 1'b0;
      r_overflow <= 1'b0;
      r_rco <= 1'b0;
    end else if (bus.i_clear) begin
      r_state <= IDLE;
      r_count <= '0;
      r_running <= 1'b0;
      r_held <= 1'b0;
      r_overflow <= 1'b0;
      r_rco <= 1'b0;
    end else begin
      r_rco <= 1'b0;
      case (r_state)
        IDLE: if (bus.i_start) begin
          r_state <= RUN;
          r_running <= 1'b1;
        end
        RUN: if (bus.i_stop) begin
          r_state <= HOLD;
          r_running <= 1'b0;
          r_held <= 1'b1;
        end else if (bus.i_tick) begin
          // saturating mode keeps all-9s; wrapping mode takes the natural carry-out value of 0
          r_count <= (w_carry[DIGITS] && SATURATE != 0) ? r_count : w_next;
          if (w_carry[DIGITS]) begin
            r_overflow <= 1'b1;
            r_rco <= 1'b1;
            if (SATURATE != 0) begin
              r_state <= OVF;
              r_running <= 1'b0;
            end
          end
        end
        OVF: if (bus.i_stop) begin
          r_state <= HOLD;
          r_held <= 1'b1;
        end else if (bus.i_start) begin
          r_state <= RUN;
          r_running <= 1'b1;
          r_count <= '0;
          r_overflow <= 1'b0;
        end
        default: if (bus.i_start) begin
          r_state <= RUN;
          r_running <= 1'b1;
          r_held <= 1'b0;
          r_count <= '0;
          r_overflow <= 1'b0;
        end
      endcase
    end
  end
  assign bus.o_count = r_count;
  assign bus.o_running = r_running;
  assign bus.o_held = r_held;
  assign bus.o_overflow = r_overflow;
  assign bus.o_ripplecarryout = r_rco;
endmodule

// File: tb/tb_bcd_multi_digit_timer.sv
// tb_bcd_multi_digit_timer: three timer configurations driven in lockstep against an integer reference model
module tb_bcd_multi_digit_timer;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_OVF = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic clear = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  int n_pass = 0, n_tot = 0;
  int nd[3] = '{4, 2, 2};
  int sat[3] = '{1, 1, 0};
  int m_st[3], m_val[3], m_ov[3], m_rc[3];
  logic [15:0] g_cnt[3];
  logic [3:0] g_flg[3];
  always #5 clk = ~clk;
  bcd_multi_digit_timer_if #(.DIGITS(4)) if4 ();
  bcd_multi_digit_timer_if #(.DIGITS(2)) if2s ();
  bcd_multi_digit_timer_if #(.DIGITS(2)) if2w ();
  bcd_multi_digit_timer #(.DIGITS(4), .SATURATE(1)) dut4 (.i_clk(clk), .i_reset(reset), .bus(if4));
  bcd_multi_digit_timer #(.DIGITS(2), .SATURATE(1)) dut2s (.i_clk(clk), .i_reset(reset), .bus(if2s));
  bcd_multi_digit_timer #(.DIGITS(2), .SATURATE(0)) dut2w (.i_clk(clk), .i_reset(reset), .bus(if2w));
  assign {if4.i_clear, if4.i_start, if4.i_stop, if4.i_tick} = {clear, start, stop, tick};
  assign {if2s.i_clear, if2s.i_start, if2s.i_stop, if2s.i_tick} = {clear, start, stop, tick};
  assign {if2w.i_clear, if2w.i_start, if2w.i_stop, if2w.i_tick} = {clear, start, stop, tick};
  assign g_cnt[0] = if4.o_count;
  assign g_cnt[1] = {8'h00, if2s.o_count};
  assign g_cnt[2] = {8'h00, if2w.o_count};
  assign g_flg[0] = {if4.o_running, if4.o_held, if4.o_overflow, if4.o_ripplecarryout};
  assign g_flg[1] = {if2s.o_running, if2s.o_held, if2s.o_overflow, if2s.o_ripplecarryout};
  assign g_flg[2] = {if2w.o_running, if2w.o_held, if2w.o_overflow, if2w.o_ripplecarryout};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int max_of(input int digits);
    int m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction
  task automatic model_rst();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = M_IDLE;
      m_val[k] = 0;
      m_ov[k] = 0;
      m_rc[k] = 0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_rc[k] = 0;
      if (clear) begin
        m_st[k] = M_IDLE;
        m_val[k] = 0;
        m_ov[k] = 0;
      end else if (m_st[k] == M_IDLE) begin
        if (start) m_st[k] = M_RUN;
      end else if (m_st[k] == M_RUN) begin
        if (stop) m_st[k] = M_HOLD;
        else if (tick) begin
          if (m_val[k] == max_of(nd[k])) begin
            m_ov[k] = 1;
            m_rc[k] = 1;
            if (sat[k] != 0) m_st[k] = M_OVF;
            else m_val[k] = 0;
          end else m_val[k]++;
        end
      end else if (stop && m_st[k] == M_OVF) m_st[k] = M_HOLD;
      else if (start) begin
        m_st[k] = M_RUN;
        m_val[k] = 0;
        m_ov[k] = 0;
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("count[%0d]", k), 32'(g_cnt[k]), 32'(to_bcd(m_val[k])));
      chk($sformatf("run/held/ovf/rco[%0d]", k), 32'(g_flg[k]),
          32'({m_st[k] == M_RUN, m_st[k] == M_HOLD, m_ov[k] != 0, m_rc[k] != 0}));
    end
  endtask
  task automatic step(input logic c, input logic sa, input logic so, input logic t);
    {clear, start, stop, tick} = {c, sa, so, t};
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic async_rst();
    #2 reset = 1'b1;
    #1 model_rst();
    check_all();
    #1 reset = 1'b0;
  endtask
  initial begin
    model_rst();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    @(negedge clk);
    step(0, 1, 0, 0);
    repeat (37) step(0, 0, 0, 1);
    chk("count_37", 32'(g_cnt[0]), 32'h0037);
    async_rst();
    step(0, 1, 0, 0);
    repeat (10005) step(0, 0, 0, 1);
    chk("count4_sat", 32'(g_cnt[0]), 32'h9999);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (42) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("hold_42", 32'(g_cnt[0]), 32'h0042);
    repeat (5) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (120) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    chk("clear_over_start", 32'(g_flg[2]), 32'h0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(31) == 0, $urandom_range(3) != 0);
      if ($urandom_range(499) == 0) async_rst();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
